// File: rtl/game_sequencer.sv
// game_sequencer: dot-runner controller sequencing IDLE/ARM/RUN/OVER, frame-aligned scroll steps,
// speed levels and collision detection. Define GAME_PAUSE_EN to add pause_btn and a PAUSE sub-state.
module game_sequencer #(
    parameter logic [23:0] BASE_RATE       = 24'd3000000,
    parameter logic [23:0] RATE_STEP       = 24'd200000,
    parameter logic [23:0] MIN_RATE        = 24'd600000,
    parameter logic [7:0]  STEPS_PER_LEVEL = 8'd64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go_btn,
    input  logic       stop_btn,
    input  logic       frame_done,
    input  logic [6:0] runner_h,
    input  logic [1:0] obstacle_h,
`ifdef GAME_PAUSE_EN
    input  logic       pause_btn,
`endif
    output logic       start,
    output logic       step,
    output logic       crash,
    output logic [3:0] level,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        go_prev_q, stop_prev_q;
    logic        go_rise, stop_rise;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic [23:0] cur_rate_q, cur_rate_d;
    logic        pending_q, pending_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [3:0]  level_q, level_d;
    logic        step_q, step_d;
    logic        crash_q, crash_d;
    logic        start_q, start_d;
    logic        chk_q, chk_d;
    logic        running, expire, step_fire, collide;
    logic [24:0] rate_floor;

    assign go_rise    = go_btn & ~go_prev_q;
    assign stop_rise  = stop_btn & ~stop_prev_q;
    assign rate_floor = {1'b0, MIN_RATE} + {1'b0, RATE_STEP};

`ifdef GAME_PAUSE_EN
    logic pause_prev_q, pause_rise;
    logic paused_q, paused_d;
    assign pause_rise = pause_btn & ~pause_prev_q;
    assign running    = (state_q == S_RUN) && !paused_q;
    // A step is withheld on the pause edge so pending survives into PAUSE
    assign step_fire  = running && !pause_rise && frame_done && (pending_q || expire);
`else
    assign running    = (state_q == S_RUN);
    assign step_fire  = running && frame_done && (pending_q || expire);
`endif

    assign expire  = running && (tick_cnt_q == 24'd0);
    // chk_q marks the cycle after a step, when the datapath has settled
    assign collide = running && chk_q && (obstacle_h != 2'd0) && (runner_h <= {5'b0, obstacle_h});

    // Next-state logic; collision outranks stop
    always_comb begin
        state_d = state_q;
`ifdef GAME_PAUSE_EN
        paused_d = paused_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go_rise) state_d = S_ARM;
                else         state_d = S_IDLE;
            end
            S_ARM: state_d = S_RUN;
            S_RUN: begin
`ifdef GAME_PAUSE_EN
                if (paused_q) begin
                    if (stop_rise) begin
                        state_d  = S_IDLE;
                        paused_d = 1'b0;
                    end else if (pause_rise) paused_d = 1'b0;
                    else                     paused_d = 1'b1;
                end else if (collide)   state_d  = S_OVER;
                else if (stop_rise)     state_d  = S_IDLE;
                else if (pause_rise)    paused_d = 1'b1;
                else                    state_d  = S_RUN;
`else
                if (collide)        state_d = S_OVER;
                else if (stop_rise) state_d = S_IDLE;
                else                state_d = S_RUN;
`endif
            end
            S_OVER: begin
                if (go_rise) state_d = S_IDLE;
                else         state_d = S_OVER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tick timer, pending flag and level/rate progression
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        pending_d  = pending_q;
        step_cnt_d = step_cnt_q;
        level_d    = level_q;
        cur_rate_d = cur_rate_q;
        if (state_q == S_ARM) begin
            tick_cnt_d = BASE_RATE - 24'd1;
            pending_d  = 1'b0;
            step_cnt_d = 8'd0;
            level_d    = 4'd0;
            cur_rate_d = BASE_RATE;
        end else if (running) begin
            if (expire) tick_cnt_d = cur_rate_q - 24'd1;
            else        tick_cnt_d = tick_cnt_q - 24'd1;
            pending_d = (pending_q | expire) & ~step_fire;
            if (step_fire) begin
                if (step_cnt_q == STEPS_PER_LEVEL - 8'd1) begin
                    step_cnt_d = 8'd0;
                    if (level_q != 4'd15) level_d = level_q + 4'd1;
                    else                  level_d = level_q;
                    if ({1'b0, cur_rate_q} >= rate_floor) cur_rate_d = cur_rate_q - RATE_STEP;
                    else                                  cur_rate_d = MIN_RATE;
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end else begin
                step_cnt_d = step_cnt_q;
            end
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Registered output values derived from the next state
    always_comb begin
        step_d  = step_fire && (state_d == S_RUN);
        chk_d   = step_q;
        crash_d = (state_d == S_OVER);
        start_d = (state_d == S_IDLE) || (state_d == S_ARM);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            go_prev_q   <= 1'b0;
            stop_prev_q <= 1'b0;
            tick_cnt_q  <= BASE_RATE - 24'd1;
            cur_rate_q  <= BASE_RATE;
            pending_q   <= 1'b0;
            step_cnt_q  <= 8'd0;
            level_q     <= 4'd0;
            step_q      <= 1'b0;
            crash_q     <= 1'b0;
            start_q     <= 1'b1;
            chk_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_prev_q   <= go_btn;
            stop_prev_q <= stop_btn;
            tick_cnt_q  <= tick_cnt_d;
            cur_rate_q  <= cur_rate_d;
            pending_q   <= pending_d;
            step_cnt_q  <= step_cnt_d;
            level_q     <= level_d;
            step_q      <= step_d;
            crash_q     <= crash_d;
            start_q     <= start_d;
            chk_q       <= chk_d;
        end
    end

`ifdef GAME_PAUSE_EN
    // Pause button edge detect and pause flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pause_prev_q <= 1'b0;
            paused_q     <= 1'b0;
        end else begin
            pause_prev_q <= pause_btn;
            paused_q     <= paused_d;
        end
    end
`endif

    assign start = start_q;
    assign step  = step_q;
    assign crash = crash_q;
    assign level = level_q;
    assign state = state_q;

endmodule
